// File: rtl/clock_sequencer_pkg.sv
// Shared types for the CPU clock sequencer.
// State encoding and cycle counter width.
package clock_pkg;

  localparam int CYC_W = 16;

  typedef enum logic [2:0] {
    RUN_HI    = 3'd0,
    RUN_LO    = 3'd1,
    STEP_IDLE = 3'd2,
    STEP_HI   = 3'd3,
    STEP_LO   = 3'd4,
    HALTED    = 3'd5
  } state_e;

endpackage

// File: rtl/clock_sequencer_if.sv
// CPU-side bundle: hlt in; clk_out, clk_rise, halted, step_mode out.
// Adds cycle_cnt when CLOCK_SEQ_CYCLE_COUNT_EN is defined.
interface clock_sequencer_if;
  import clock_pkg::*;

  logic hlt;
  logic clk_out;
  logic clk_rise;
  logic halted;
  logic step_mode;
`ifdef CLOCK_SEQ_CYCLE_COUNT_EN
  logic [CYC_W-1:0] cycle_cnt;
`endif

  modport master (
    input  hlt,
`ifdef CLOCK_SEQ_CYCLE_COUNT_EN
    output cycle_cnt,
`endif
    output clk_out,
    output clk_rise,
    output halted,
    output step_mode
  );

  modport slave (
    output hlt,
`ifdef CLOCK_SEQ_CYCLE_COUNT_EN
    input  cycle_cnt,
`endif
    input  clk_out,
    input  clk_rise,
    input  halted,
    input  step_mode
  );

endinterface

// File: rtl/clock_sequencer_input_debouncer.sv
// 2-FF synchronizer plus stability debouncer.
// Ports: clk_i, rst_ni, d_i (async raw), q_o (debounced).
module input_debouncer #(
  parameter int   DEBOUNCE = 16,
  parameter logic RST_VAL  = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  localparam int CW = $clog2(DEBOUNCE) + 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

  logic          s1_q, s2_q;
  logic          out_q, out_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A differing sample bumps the count; any agreeing
  // sample restarts it, so only a stable run commits.
  always_comb begin
    out_d = out_q;
    cnt_d = '0;
    if (s2_q != out_q) begin
      if (cnt_q == LAST) begin
        out_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_q  <= RST_VAL;
      s2_q  <= RST_VAL;
      out_q <= RST_VAL;
      cnt_q <= '0;
    end else begin
      s1_q  <= d_i;
      s2_q  <= s1_q;
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign q_o = out_q;

endmodule

// File: rtl/clock_sequencer.sv
// Glitch-free CPU clock sequencer: run/step/halt.
// Ports: clk_base, rst (async low), step_btn, step_en, bus (master).
// Option: CLOCK_SEQ_CYCLE_COUNT_EN adds bus.cycle_cnt.
module clock_sequencer
  import clock_pkg::*;
#(
  parameter int DIVISOR  = 2,
  parameter int DEBOUNCE = 16
) (
  input  logic clk_base,
  input  logic rst,
  input  logic step_btn,
  input  logic step_en,
  clock_sequencer_if.master bus
);

  localparam int PW = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [PW-1:0] LAST = PW'(DIVISOR - 1);

  state_e        state_q, state_d;
  logic [PW-1:0] ph_q, ph_d;
  logic          pend_q, pend_d;
  logic          mode_q, mode_d;
  logic          btn_prev_q;
  logic          clk_out_q, clk_out_d;
  logic          rise_q, halted_q;
  logic          btn_db, en_db, btn_rise, last;

  input_debouncer #(.DEBOUNCE(DEBOUNCE), .RST_VAL(1'b0)) u_btn (
    .clk_i (clk_base),
    .rst_ni(rst),
    .d_i   (step_btn),
    .q_o   (btn_db)
  );

  input_debouncer #(.DEBOUNCE(DEBOUNCE), .RST_VAL(1'b1)) u_en (
    .clk_i (clk_base),
    .rst_ni(rst),
    .d_i   (step_en),
    .q_o   (en_db)
  );

  assign btn_rise = btn_db & ~btn_prev_q;
  assign last     = (ph_q == LAST);

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q + PW'(1);
    pend_d  = pend_q;
    mode_d  = mode_q;
    if (btn_rise && !pend_q) pend_d = 1'b1;
    case (state_q)
      RUN_HI: begin
        if (last) begin
          state_d = RUN_LO;
          ph_d    = '0;
        end
      end
      RUN_LO: begin
        if (last) begin
          ph_d = '0;
          if (bus.hlt) begin
            state_d = HALTED;
          end else if (en_db) begin
            state_d = STEP_IDLE;
            mode_d  = 1'b1;
          end else begin
            state_d = RUN_HI;
            pend_d  = 1'b0;
          end
        end
      end
      STEP_IDLE: begin
        ph_d = '0;
        if (bus.hlt) begin
          state_d = HALTED;
        end else if (!en_db) begin
          // Leaving step mode discards any press.
          state_d = RUN_HI;
          mode_d  = 1'b0;
          pend_d  = 1'b0;
        end else if (pend_q) begin
          state_d = STEP_HI;
          pend_d  = 1'b0;
        end
      end
      STEP_HI: begin
        if (last) begin
          state_d = STEP_LO;
          ph_d    = '0;
        end
      end
      STEP_LO: begin
        if (last) begin
          state_d = STEP_IDLE;
          ph_d    = '0;
        end
      end
      HALTED: begin
        ph_d = '0;
        if (!bus.hlt) begin
          if (en_db) begin
            state_d = STEP_IDLE;
            mode_d  = 1'b1;
          end else begin
            state_d = RUN_HI;
            mode_d  = 1'b0;
            pend_d  = 1'b0;
          end
        end
      end
      default: begin
        state_d = STEP_IDLE;
        ph_d    = '0;
      end
    endcase
  end

  // Outputs register off the next state so they
  // align with the state they describe.
  assign clk_out_d = (state_d == RUN_HI) ||
                     (state_d == STEP_HI);

  always_ff @(posedge clk_base or negedge rst) begin
    if (!rst) begin
      state_q    <= STEP_IDLE;
      ph_q       <= '0;
      pend_q     <= 1'b0;
      mode_q     <= 1'b1;
      btn_prev_q <= 1'b0;
      clk_out_q  <= 1'b0;
      rise_q     <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      pend_q     <= pend_d;
      mode_q     <= mode_d;
      btn_prev_q <= btn_db;
      clk_out_q  <= clk_out_d;
      rise_q     <= clk_out_d & ~clk_out_q;
      halted_q   <= (state_d == HALTED);
    end
  end

  assign bus.clk_out   = clk_out_q;
  assign bus.clk_rise  = rise_q;
  assign bus.halted    = halted_q;
  assign bus.step_mode = mode_q;

`ifdef CLOCK_SEQ_CYCLE_COUNT_EN
  logic [CYC_W-1:0] cyc_q;

  always_ff @(posedge clk_base or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
    end else if (rise_q) begin
      cyc_q <= cyc_q + CYC_W'(1);
    end
  end

  assign bus.cycle_cnt = cyc_q;
`endif

endmodule
